// File: rtl/tm1638_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter feeding the TM1638 seg0..seg7 inputs.
// Optional leading-zero blanking is enabled by defining TM1638_BIN2BCD_BLANK_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start_i; captures bin_i on the accept edge
// S_SHIFT  | one add-3 + shift iteration per cycle, BIN_W iterations
// S_FINISH | register digits/overflow into outputs, pulse done_o
module tm1638_bin2bcd #(
  parameter int         BIN_W      = 27,
  parameter int         DIGITS     = 8,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [3:0]       seg0_o,
  output logic [3:0]       seg1_o,
  output logic [3:0]       seg2_o,
  output logic [3:0]       seg3_o,
  output logic [3:0]       seg4_o,
  output logic [3:0]       seg5_o,
  output logic [3:0]       seg6_o,
  output logic [3:0]       seg7_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SH_W  = BCD_W + BIN_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      seg_q, seg_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [SH_W-1:0]  shifted;
  logic [BCD_W-1:0] disp;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {1'b0, bcd_adj, bin_q} << 1;
  end

  // Saturate to all nines on overflow; blanking only applies to exact values.
  always_comb begin
    if (sticky_q) begin
      disp = {DIGITS{4'h9}};
    end else begin
      disp = bcd_q;
`ifdef TM1638_BIN2BCD_BLANK_EN
      begin
        logic seen;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
          if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
          else if (!seen) disp[4*i +: 4] = BLANK_CODE;
        end
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    seg_d    = seg_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bin_d    = bin_i;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d    = shifted[SH_W-2 -: BCD_W];
        bin_d    = shifted[BIN_W-1:0];
        sticky_d = sticky_q | shifted[SH_W-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        seg_d              = '0;
        seg_d[BCD_W-1:0]   = disp;
        ovf_d              = sticky_q;
        done_d             = 1'b1;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      seg_q    <= seg_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign seg0_o = seg_q[3:0];
  assign seg1_o = seg_q[7:4];
  assign seg2_o = seg_q[11:8];
  assign seg3_o = seg_q[15:12];
  assign seg4_o = seg_q[19:16];
  assign seg5_o = seg_q[23:20];
  assign seg6_o = seg_q[27:24];
  assign seg7_o = seg_q[31:28];

endmodule

// File: tb/tb_tm1638_bin2bcd.sv
// Scoreboard bench for tm1638_bin2bcd: expected digits are queued at each accepted START
// and compared when DONE pulses; also checks latency, BUSY width, hold and reset behaviour.
module tb_tm1638_bin2bcd;
  localparam int BIN_W = 27;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             start_i;
  logic [BIN_W-1:0] bin_i;
  logic             busy_o, done_o, ovf_o;
  logic [3:0]       seg0_o, seg1_o, seg2_o, seg3_o, seg4_o, seg5_o, seg6_o, seg7_o;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] last_seg = '0;
  logic        last_ovf = 1'b0;
  logic        prev_done = 1'b0;
  int          edges, busy_cyc;

  tm1638_bin2bcd #(.BIN_W(BIN_W), .DIGITS(8), .BLANK_CODE(4'hF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .bin_i(bin_i),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
    .seg0_o(seg0_o), .seg1_o(seg1_o), .seg2_o(seg2_o), .seg3_o(seg3_o),
    .seg4_o(seg4_o), .seg5_o(seg5_o), .seg6_o(seg6_o), .seg7_o(seg7_o)
  );

  always #5 clk_i = ~clk_i;

  wire [31:0] seg_flat = {seg7_o, seg6_o, seg5_o, seg4_o, seg3_o, seg2_o, seg1_o, seg0_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {ovf, seg7..seg0} from plain decimal arithmetic.
  function automatic logic [32:0] model(input int unsigned v);
    logic [31:0] s;
    int unsigned r;
    logic        seen;
    if (v > 99999999) return {1'b1, 32'h99999999};
    s = '0;
    r = v;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef TM1638_BIN2BCD_BLANK_EN
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (s[4*i +: 4] != 4'd0) seen = 1'b1;
      else if (!seen) s[4*i +: 4] = 4'hF;
    end
`else
    seen = 1'b0;
`endif
    return {1'b0, s};
  endfunction

  always @(negedge clk_i) begin
    if (done_o) begin
      check("done_single", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("seg", {32'd0, seg_flat}, {32'd0, e[31:0]});
        check("ovf", {63'd0, ovf_o}, {63'd0, e[32]});
        last_seg = e[31:0];
        last_ovf = e[32];
      end
    end else begin
      check("hold_seg", {32'd0, seg_flat}, {32'd0, last_seg});
      check("hold_ovf", {63'd0, ovf_o}, {63'd0, last_ovf});
    end
    prev_done = done_o;
  end

  task automatic start_conv(input int unsigned v);
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = BIN_W'(v);
    @(posedge clk_i);
    exp_q.push_back(model(v));
    #1;
    start_i = 1'b0;
    check("busy_accept", {63'd0, busy_o}, 64'd1);
  endtask

  // Called 1 time unit after the accept edge; counts edges until DONE and BUSY cycles.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = -1;
    n_busy  = busy_o ? 1 : 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        n_edges = n;
        break;
      end
      if (busy_o) n_busy++;
    end
    if (n_edges < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0;
    bin_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_ovf", {63'd0, ovf_o}, 64'd0);
    check("rst_seg", {32'd0, seg_flat}, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Zero: latency and BUSY width
    start_conv(0);
    wait_done(edges, busy_cyc);
    check("latency_zero", edges, BIN_W + 1);
    check("busy_zero", busy_cyc, BIN_W + 1);
    check("busy_at_done", {63'd0, busy_o}, 64'd0);

    start_conv(22119211);
    wait_done(edges, busy_cyc);
    check("latency_22119211", edges, BIN_W + 1);
    check("busy_22119211", busy_cyc, BIN_W + 1);
    check("digits_22119211", {32'd0, seg_flat}, 64'h22119211);
    repeat (3) @(posedge clk_i);

    // Back-to-back with START held high
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = BIN_W'(99999999);
    @(posedge clk_i);
    exp_q.push_back(model(99999999));
    #1;
    bin_i = BIN_W'(100000000);
    for (int n = 1; n <= BIN_W + 1; n++) @(posedge clk_i);
    #1;
    check("b2b_first_done", {63'd0, done_o}, 64'd1);
    check("b2b_idle_at_done", {63'd0, busy_o}, 64'd0);
    @(posedge clk_i);
    exp_q.push_back(model(100000000));
    #1;
    check("b2b_second_accept", {63'd0, busy_o}, 64'd1);
    start_i = 1'b0;
    wait_done(edges, busy_cyc);
    check("b2b_latency", edges, BIN_W + 1);
    check("b2b_ovf", {63'd0, ovf_o}, 64'd1);
    repeat (2) @(posedge clk_i);

    // START during BUSY is ignored
    start_conv(12345678);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = BIN_W'(1);
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    wait_done(edges, busy_cyc);
    check("ignore_latency", edges, BIN_W + 1 - 6);
    repeat (40) @(posedge clk_i);
    #1;
    check("ignore_no_busy", {63'd0, busy_o}, 64'd0);

    // Reset mid-conversion
    start_conv(87654321);
    repeat (10) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    exp_q.delete();
    last_seg = '0;
    last_ovf = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_ovf", {63'd0, ovf_o}, 64'd0);
    check("midrst_seg", {32'd0, seg_flat}, 64'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (40) @(posedge clk_i);
    start_conv(5);
    wait_done(edges, busy_cyc);
    check("after_rst_latency", edges, BIN_W + 1);

    start_conv(4096);
    wait_done(edges, busy_cyc);
`ifdef TM1638_BIN2BCD_BLANK_EN
    check("blank_4096", {32'd0, seg_flat}, 64'hFFFF4096);
    start_conv(0);
    wait_done(edges, busy_cyc);
    check("blank_zero", {32'd0, seg_flat}, 64'hFFFFFFF0);
`else
    check("noblank_4096", {32'd0, seg_flat}, 64'h00004096);
`endif

    start_conv(134217727);
    wait_done(edges, busy_cyc);
    for (int k = 0; k < 4; k++) begin
      start_conv($urandom_range(99999999, 0));
      wait_done(edges, busy_cyc);
    end

    repeat (3) @(posedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end
endmodule
